ssp_rx_controller: RTL and testbench
====================================

Name: ssp_rx_controller

Overview:
- Receive-side controller for the SSP serial-to-parallel deserializer.
- Sequences the deserializer's clear and arming, and captures each completed frame (REQ pulse + data) into a small FIFO.
- Arbitrates FIFO push (from the deserializer) against pop (from the host side).
- Raises threshold, timeout and overrun interrupts. Sits between the deserializer and the SSP register/bus interface.

Parameters:
- DATA_WIDTH, 8, frame width; must match the deserializer.
- FIFO_DEPTH, 4, number of entries; power of two.
- ADDR_WIDTH, 2, log2(FIFO_DEPTH).
- RX_THRESHOLD, 2, level at or above which o_RX_INT asserts; range 1..FIFO_DEPTH.
- TIMEOUT_CYCLES, 32, idle cycles with non-empty FIFO before o_TIMEOUT_INT sets; minimum 2.

Ports:
- i_SSPCLKIN  in  1  single clock; all logic on its posedge.
- i_CLEAR  in  1  reset; asynchronous, active-high.
- i_ENABLE  in  1  receive enable.
- i_FLUSH  in  1  single-cycle pulse; discard FIFO contents and re-arm.
- i_RX_REQ  in  1  frame-complete pulse from the deserializer.
- i_RX_DATA  in  DATA_WIDTH  frame from the deserializer; valid when i_RX_REQ=1.
- o_DESER_CLEAR_B  out  1  drives the deserializer's active-low synchronous clear.
- i_RD_EN  in  1  host pop request.
- o_RD_DATA  out  DATA_WIDTH  popped frame.
- o_RD_VALID  out  1  one-cycle pulse; o_RD_DATA valid.
- o_LEVEL  out  ADDR_WIDTH+1  current FIFO occupancy.
- o_FULL  out  1  FIFO full.
- o_EMPTY  out  1  FIFO empty.
- o_RX_INT  out  1  level >= RX_THRESHOLD.
- o_TIMEOUT_INT  out  1  stale-data interrupt.
- o_OVERRUN_INT  out  1  sticky overrun flag.
- i_INT_CLR  in  1  clears o_OVERRUN_INT.

Behaviour:
- Reset values (async, i_CLEAR=1):
  - state=DISABLED; o_DESER_CLEAR_B=0.
  - FIFO pointers and o_LEVEL=0; o_EMPTY=1; o_FULL=0.
  - o_RD_DATA=0; o_RD_VALID=0.
  - o_RX_INT=0; o_TIMEOUT_INT=0; o_OVERRUN_INT=0; timeout counter=0.
- FSM states: DISABLED, ARMING, ACTIVE, FLUSH.
  - DISABLED: o_DESER_CLEAR_B=0; pushes ignored. Goes to ARMING when i_ENABLE=1.
  - ARMING: exactly one cycle with o_DESER_CLEAR_B=0, then ACTIVE. This guarantees the deserializer clocks at least one clear cycle before release.
  - ACTIVE: o_DESER_CLEAR_B=1; pushes accepted. Goes to DISABLED when i_ENABLE=0; goes to FLUSH on i_FLUSH=1.
  - FLUSH: one cycle. Pointers and level reset to 0, o_DESER_CLEAR_B=0, timeout cleared. Then ARMING if i_ENABLE=1, else DISABLED.
  - i_FLUSH in DISABLED also empties the FIFO the same cycle; state stays DISABLED.
  - FIFO contents are kept across DISABLED; the host may keep popping while disabled.
- Push:
  - Occurs in ACTIVE with i_RX_REQ=1 and (not full, or a pop in the same cycle). Data written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
  - i_RX_REQ while full with no pop: frame dropped, o_OVERRUN_INT set next cycle, FIFO unchanged.
- Pop:
  - i_RD_EN=1 and not empty: o_RD_DATA registered from the read pointer; o_RD_VALID=1 on the next cycle; read pointer increments and wraps.
  - i_RD_EN while empty is ignored (o_RD_VALID stays 0). There is no fall-through: a same-cycle push into an empty FIFO is not readable that cycle.
- Simultaneous push and pop when not empty: both happen, level unchanged.
- o_LEVEL, o_FULL and o_EMPTY are registered and update the cycle after a push or pop.
- o_RX_INT is combinational from registered o_LEVEL (o_LEVEL >= RX_THRESHOLD).
- Timeout:
  - Counter resets to 0 on any push, any pop, or when the FIFO is empty; otherwise it increments and saturates.
  - When the counter reaches TIMEOUT_CYCLES-1, o_TIMEOUT_INT=1. It stays set until the counter resets.
- o_OVERRUN_INT:
  - Sticky; cleared only by i_INT_CLR or reset.
  - If a new overrun and i_INT_CLR occur in the same cycle, set wins.
- Reset mid-frame or mid-pop: all state is lost immediately; the deserializer is held in clear.

Optional Feature:
- Macro SSP_RX_FRAME_CNT_EN.
- Defined: adds output o_FRAME_CNT [15:0].
  - Counts accepted pushes; wraps 0xFFFF->0.
  - Reset to 0 by i_CLEAR or FLUSH.
  - Dropped (overrun) frames are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then i_ENABLE=1 -> o_DESER_CLEAR_B low for the DISABLED cycles plus exactly 1 ARMING cycle, then high; o_EMPTY=1; o_LEVEL=0.
- Push 0xA5, 0x3C, then pop twice -> o_RD_DATA=0xA5 then 0x3C, each with a 1-cycle o_RD_VALID; o_RX_INT high while level=2; o_EMPTY=1 at the end.
- Push 5 frames 0x01..0x05 with no pops -> o_FULL=1, o_OVERRUN_INT=1; pops return 0x01..0x04; 0x05 lost; i_INT_CLR clears the flag.
- While full, push 0x77 and pop in the same cycle -> no overrun, o_LEVEL stays 4; 0x77 is read last after the remaining entries.
- One frame pushed, then 31 idle cycles -> o_TIMEOUT_INT=1 at cycle 31; a pop clears it and empties the FIFO.
- Three frames stored, i_FLUSH pulse -> o_LEVEL=0 next cycle, o_DESER_CLEAR_B low during FLUSH and ARMING, then high; with SSP_RX_FRAME_CNT_EN, o_FRAME_CNT goes 3->0.

Source files
------------

// File: rtl/ssp_rx_controller.sv
// Receive-side controller for the SSP deserializer: arming FSM, frame FIFO, interrupts.
// Optional: define SSP_RX_FRAME_CNT_EN to add the o_FRAME_CNT accepted-frame counter.
module ssp_rx_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 2,
  parameter int RX_THRESHOLD   = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  i_SSPCLKIN,
  input  logic                  i_CLEAR,
  input  logic                  i_ENABLE,
  input  logic                  i_FLUSH,
  input  logic                  i_RX_REQ,
  input  logic [DATA_WIDTH-1:0] i_RX_DATA,
  output logic                  o_DESER_CLEAR_B,
  input  logic                  i_RD_EN,
  output logic [DATA_WIDTH-1:0] o_RD_DATA,
  output logic                  o_RD_VALID,
  output logic [ADDR_WIDTH:0]   o_LEVEL,
  output logic                  o_FULL,
  output logic                  o_EMPTY,
  output logic                  o_RX_INT,
  output logic                  o_TIMEOUT_INT,
  output logic                  o_OVERRUN_INT,
  input  logic                  i_INT_CLR
`ifdef SSP_RX_FRAME_CNT_EN
  ,
  output logic [15:0]           o_FRAME_CNT
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]       TMO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] THR_LVL   = (ADDR_WIDTH + 1)'(RX_THRESHOLD);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMING   = 2'd1,
    ACTIVE   = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, empty_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  ovr_q, ovr_d;

  logic flush_clr, push, pop, overrun;

  // Flush empties the FIFO on the edge it is seen and keeps it empty through FLUSH.
  assign flush_clr = (i_FLUSH && (state_q == DISABLED || state_q == ACTIVE)) ||
                     (state_q == FLUSH);
  assign pop       = i_RD_EN && !empty_q && !flush_clr;
  assign push      = (state_q == ACTIVE) && i_RX_REQ && !flush_clr && (!full_q || pop);
  assign overrun   = (state_q == ACTIVE) && i_RX_REQ && !flush_clr && full_q && !pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED: if (i_ENABLE) state_d = ARMING;
      ARMING:   state_d = ACTIVE;
      ACTIVE: begin
        if (i_FLUSH)        state_d = FLUSH;
        else if (!i_ENABLE) state_d = DISABLED;
      end
      FLUSH:    state_d = i_ENABLE ? ARMING : DISABLED;
      default:  state_d = DISABLED;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (flush_clr || push || pop || empty_q) tmo_cnt_d = '0;
    else if (tmo_cnt_q != TMO_MAX)           tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // A fresh overrun beats a same-cycle clear so no event is lost.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun)        ovr_d = 1'b1;
    else if (i_INT_CLR) ovr_d = 1'b0;
  end

  always_ff @(posedge i_SSPCLKIN or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      state_q    <= DISABLED;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      tmo_cnt_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH_LVL);
      empty_q    <= (level_d == '0);
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rptr_q];
      tmo_cnt_q  <= tmo_cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  // Storage has no reset so it maps onto RAM; a full-FIFO read+write sees old data.
  always_ff @(posedge i_SSPCLKIN) begin
    if (push) mem_q[wptr_q] <= i_RX_DATA;
  end

`ifdef SSP_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (flush_clr) frame_cnt_d = '0;
    else if (push) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge i_SSPCLKIN or posedge i_CLEAR) begin
    if (i_CLEAR) frame_cnt_q <= '0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign o_FRAME_CNT = frame_cnt_q;
`endif

  assign o_DESER_CLEAR_B = (state_q == ACTIVE);
  assign o_RD_DATA       = rd_data_q;
  assign o_RD_VALID      = rd_valid_q;
  assign o_LEVEL         = level_q;
  assign o_FULL          = full_q;
  assign o_EMPTY         = empty_q;
  assign o_RX_INT        = (level_q >= THR_LVL);
  assign o_TIMEOUT_INT   = (tmo_cnt_q == TMO_MAX);
  assign o_OVERRUN_INT   = ovr_q;

endmodule

// File: tb/tb_ssp_rx_controller.sv
// Directed self-checking bench for ssp_rx_controller (default parameters).
// Honours SSP_RX_FRAME_CNT_EN when the design is built with it.
module tb_ssp_rx_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, flush, rx_req, rd_en, int_clr;
  logic [7:0] rx_data;
  logic       deser_clear_b, rd_valid, full, empty, rx_int, tmo_int, ovr_int;
  logic [7:0] rd_data;
  logic [2:0] level;
`ifdef SSP_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ssp_rx_controller dut (
    .i_SSPCLKIN     (clk),
    .i_CLEAR        (rst),
    .i_ENABLE       (enable),
    .i_FLUSH        (flush),
    .i_RX_REQ       (rx_req),
    .i_RX_DATA      (rx_data),
    .o_DESER_CLEAR_B(deser_clear_b),
    .i_RD_EN        (rd_en),
    .o_RD_DATA      (rd_data),
    .o_RD_VALID     (rd_valid),
    .o_LEVEL        (level),
    .o_FULL         (full),
    .o_EMPTY        (empty),
    .o_RX_INT       (rx_int),
    .o_TIMEOUT_INT  (tmo_int),
    .o_OVERRUN_INT  (ovr_int),
    .i_INT_CLR      (int_clr)
`ifdef SSP_RX_FRAME_CNT_EN
    ,
    .o_FRAME_CNT    (frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_req  = 1'b1;
    rx_data = d;
    tick();
    rx_req  = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rd_data}, {24'd0, d});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; rx_req = 1'b0;
    rd_en = 1'b0; int_clr = 1'b0; rx_data = 8'h00;
    tick(); tick();
    check("rst_clear_b", {31'd0, deser_clear_b}, 32'd0);
    check("rst_empty",   {31'd0, empty},   32'd1);
    check("rst_full",    {31'd0, full},    32'd0);
    check("rst_level",   {29'd0, level},   32'd0);
    check("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
    check("rst_rddata",  {24'd0, rd_data}, 32'd0);
    check("rst_ints",    {29'd0, rx_int, tmo_int, ovr_int}, 32'd0);
    rst = 1'b0;
    tick();
    check("disabled_clear_b", {31'd0, deser_clear_b}, 32'd0);
    push(8'hEE);
    check("disabled_push_ignored", {29'd0, level}, 32'd0);

    // Arming: exactly one extra cleared cycle before release.
    enable = 1'b1;
    tick();
    check("arming_clear_b", {31'd0, deser_clear_b}, 32'd0);
    tick();
    check("active_clear_b", {31'd0, deser_clear_b}, 32'd1);

    // Basic push / pop.
    push(8'hA5);
    check("lvl1_rxint", {31'd0, rx_int}, 32'd0);
    push(8'h3C);
    check("lvl2_level", {29'd0, level}, 32'd2);
    check("lvl2_rxint", {31'd0, rx_int}, 32'd1);
    pop_expect("pop_a5", 8'hA5);
    check("after_pop1_rxint", {31'd0, rx_int}, 32'd0);
    pop_expect("pop_3c", 8'h3C);
    check("after_pop2_empty", {31'd0, empty}, 32'd1);
    tick();
    check("valid_one_cycle", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_empty_ignored", {31'd0, rd_valid}, 32'd0);

    // Fill, overrun, clear, then a same-cycle push+pop while full.
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("full_flag",  {31'd0, full},  32'd1);
    check("full_level", {29'd0, level}, 32'd4);
    check("no_ovr_yet", {31'd0, ovr_int}, 32'd0);
    push(8'h05);
    check("ovr_set",    {31'd0, ovr_int}, 32'd1);
    check("ovr_level",  {29'd0, level}, 32'd4);
    int_clr = 1'b1;
    tick();
    int_clr = 1'b0;
    check("ovr_cleared", {31'd0, ovr_int}, 32'd0);
    rx_req = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
    tick();
    rx_req = 1'b0; rd_en = 1'b0;
    check("pp_valid", {31'd0, rd_valid}, 32'd1);
    check("pp_data",  {24'd0, rd_data}, 32'h01);
    check("pp_level", {29'd0, level}, 32'd4);
    check("pp_no_ovr", {31'd0, ovr_int}, 32'd0);
    pop_expect("pop_02", 8'h02);
    pop_expect("pop_03", 8'h03);
    pop_expect("pop_04", 8'h04);
    pop_expect("pop_77", 8'h77);
    check("drained_empty", {31'd0, empty}, 32'd1);

    // Timeout: one frame, 31 idle cycles.
    push(8'h5A);
    for (int i = 0; i < 30; i++) tick();
    check("tmo_not_yet", {31'd0, tmo_int}, 32'd0);
    tick();
    check("tmo_set", {31'd0, tmo_int}, 32'd1);
    pop_expect("tmo_pop", 8'h5A);
    check("tmo_cleared", {31'd0, tmo_int}, 32'd0);
    check("tmo_empty",   {31'd0, empty},   32'd1);

    // Flush with three frames stored.
    push(8'h11); push(8'h22); push(8'h33);
    check("pre_flush_level", {29'd0, level}, 32'd3);
`ifdef SSP_RX_FRAME_CNT_EN
    check("pre_flush_frame_cnt", {16'd0, frame_cnt}, 32'd11);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_level",   {29'd0, level}, 32'd0);
    check("flush_empty",   {31'd0, empty}, 32'd1);
    check("flush_clear_b", {31'd0, deser_clear_b}, 32'd0);
`ifdef SSP_RX_FRAME_CNT_EN
    check("flush_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    tick();
    check("rearm_clear_b", {31'd0, deser_clear_b}, 32'd0);
    tick();
    check("reactive_clear_b", {31'd0, deser_clear_b}, 32'd1);

    // Disable; FIFO contents survive and can still be popped.
    push(8'h9C);
    enable = 1'b0;
    tick();
    check("disable_clear_b", {31'd0, deser_clear_b}, 32'd0);
    check("disable_keeps",   {29'd0, level}, 32'd1);
    pop_expect("pop_disabled", 8'h9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
